// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) shared by the memory responder and its bench.
// Signal widths follow the AXI_* parameters, which must match the attached responder.
interface axi_mem_responder_if #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 5,
    parameter int AXI_USER_WIDTH = 1
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_valid, input w_ready,
        input  b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, input ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, output aw_ready,
        input  w_data, w_strb, w_last, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate serving a register-array memory; independent single-burst read and write engines.
// Define AXI_MEM_RESP_ERRCNT_EN to build the saturating error-response counter on err_cnt_o.
module axi_mem_responder #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 5,
    parameter int AXI_USER_WIDTH = 1,
    parameter int MEM_WORDS      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_mem_responder_if.slave      slave,
    output logic                    busy_o,
    output logic [15:0]             err_cnt_o
);
    localparam int DATA_BYTES = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(DATA_BYTES);
    localparam int IDX_W      = $clog2(MEM_WORDS);
    localparam logic [AXI_ADDR_WIDTH-1:0] MEM_LIMIT  = AXI_ADDR_WIDTH'(MEM_WORDS);
    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(DATA_BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic [AXI_ADDR_WIDTH-1:0] word_of(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return (addr - BASE_ADDR) >> ADDR_LSB;
    endfunction

    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                                            input logic [1:0] burst);
        if (burst == BURST_FIXED) return addr;
        return (addr & ~(BEAT_BYTES - 1'b1)) + BEAT_BYTES;
    endfunction

    function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
        return (burst == BURST_WRAP) || (size != 3'(ADDR_LSB));
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Write engine state and captured AW fields
    w_state_t                  w_state;
    logic                      aw_ready_q, w_ready_q, b_valid_q;
    logic [AXI_ID_WIDTH-1:0]   b_id_q;
    logic [1:0]                b_resp_q;
    logic [AXI_ADDR_WIDTH-1:0] w_addr;
    logic [7:0]                w_len;
    logic [1:0]                w_burst;
    logic                      w_bad;
    logic [8:0]                w_cnt;
    logic [AXI_ADDR_WIDTH-1:0] w_word;
    logic [1:0]                w_beat_resp;
    logic                      mem_we;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_word      = word_of(w_addr);
        w_beat_resp = RESP_OKAY;
        if (w_bad || (w_cnt > {1'b0, w_len})) w_beat_resp = RESP_SLVERR;
        else if (w_word >= MEM_LIMIT)         w_beat_resp = RESP_DECERR;
        mem_we = (w_state == W_DATA) && slave.w_valid && (w_beat_resp == RESP_OKAY);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state    <= W_IDLE;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= RESP_OKAY;
            w_addr     <= '0;
            w_len      <= '0;
            w_burst    <= '0;
            w_bad      <= 1'b0;
            w_cnt      <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (slave.aw_valid) begin
                    b_id_q     <= slave.aw_id;
                    w_addr     <= slave.aw_addr;
                    w_len      <= slave.aw_len;
                    w_burst    <= slave.aw_burst;
                    w_bad      <= burst_bad(slave.aw_burst, slave.aw_size);
                    w_cnt      <= '0;
                    b_resp_q   <= RESP_OKAY;
                    aw_ready_q <= 1'b0;
                    w_ready_q  <= 1'b1;
                    w_state    <= W_DATA;
                end
                W_DATA: if (slave.w_valid) begin
                    w_cnt  <= (w_cnt == '1) ? w_cnt : w_cnt + 9'd1;
                    w_addr <= next_addr(w_addr, w_burst);
                    if (slave.w_last) begin
                        // Short or long bursts are flagged once w_last closes them
                        b_resp_q  <= resp_max(resp_max(b_resp_q, w_beat_resp),
                                              (w_cnt != {1'b0, w_len}) ? RESP_SLVERR : RESP_OKAY);
                        w_ready_q <= 1'b0;
                        b_valid_q <= 1'b1;
                        w_state   <= W_RESP;
                    end else begin
                        b_resp_q <= resp_max(b_resp_q, w_beat_resp);
                    end
                end
                W_RESP: if (slave.b_ready) begin
                    b_valid_q  <= 1'b0;
                    aw_ready_q <= 1'b1;
                    w_state    <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the memory array has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (slave.w_strb[b]) mem[w_word[IDX_W-1:0]][b*8 +: 8] <= slave.w_data[b*8 +: 8];
            end
        end
    end

    // Read engine: the beat being fetched comes from AR while idle, else from the running address
    r_state_t                  r_state;
    logic                      ar_ready_q, r_valid_q, r_last_q, r_bad, r_err;
    logic [AXI_ID_WIDTH-1:0]   r_id_q;
    logic [AXI_DATA_WIDTH-1:0] r_data_q, rd_data;
    logic [1:0]                r_resp_q, rd_resp, r_burst;
    logic [AXI_ADDR_WIDTH-1:0] r_addr, rd_addr, rd_word;
    logic [7:0]                r_len, r_beat;
    logic                      rd_bad;

    always_comb begin
        rd_addr = r_addr;
        rd_bad  = r_bad;
        if (r_state == R_IDLE) begin
            rd_addr = slave.ar_addr;
            rd_bad  = burst_bad(slave.ar_burst, slave.ar_size);
        end
        rd_word = word_of(rd_addr);
        rd_resp = RESP_OKAY;
        rd_data = '0;
        if (rd_bad)                    rd_resp = RESP_SLVERR;
        else if (rd_word >= MEM_LIMIT) rd_resp = RESP_DECERR;
        else                           rd_data = mem[rd_word[IDX_W-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= R_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            r_id_q     <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_burst    <= '0;
            r_bad      <= 1'b0;
            r_beat     <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (slave.ar_valid) begin
                    r_id_q     <= slave.ar_id;
                    r_len      <= slave.ar_len;
                    r_burst    <= slave.ar_burst;
                    r_bad      <= rd_bad;
                    r_addr     <= next_addr(slave.ar_addr, slave.ar_burst);
                    r_beat     <= '0;
                    r_data_q   <= rd_data;
                    r_resp_q   <= rd_resp;
                    r_err      <= (rd_resp != RESP_OKAY);
                    r_last_q   <= (slave.ar_len == 8'd0);
                    r_valid_q  <= 1'b1;
                    ar_ready_q <= 1'b0;
                    r_state    <= R_DATA;
                end
                R_DATA: if (slave.r_ready) begin
                    if (r_last_q) begin
                        r_valid_q  <= 1'b0;
                        r_last_q   <= 1'b0;
                        ar_ready_q <= 1'b1;
                        r_state    <= R_IDLE;
                    end else begin
                        r_beat   <= r_beat + 8'd1;
                        r_addr   <= next_addr(r_addr, r_burst);
                        r_data_q <= rd_data;
                        r_resp_q <= rd_resp;
                        r_err    <= r_err | (rd_resp != RESP_OKAY);
                        r_last_q <= ((r_beat + 8'd1) == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign slave.aw_ready = aw_ready_q;
    assign slave.w_ready  = w_ready_q;
    assign slave.b_valid  = b_valid_q;
    assign slave.b_id     = b_id_q;
    assign slave.b_resp   = b_resp_q;
    assign slave.b_user   = AXI_USER_WIDTH'(0);
    assign slave.ar_ready = ar_ready_q;
    assign slave.r_valid  = r_valid_q;
    assign slave.r_last   = r_last_q;
    assign slave.r_data   = r_data_q;
    assign slave.r_resp   = r_resp_q;
    assign slave.r_id     = r_id_q;
    assign slave.r_user   = AXI_USER_WIDTH'(0);

    assign busy_o = (w_state != W_IDLE) || (r_state != R_IDLE);

`ifdef AXI_MEM_RESP_ERRCNT_EN
    logic [15:0] err_cnt;
    logic [16:0] err_sum;
    logic        b_evt, r_evt;

    always_comb begin
        b_evt   = b_valid_q && slave.b_ready && (b_resp_q != RESP_OKAY);
        r_evt   = r_valid_q && slave.r_ready && r_last_q && r_err;
        err_sum = {1'b0, err_cnt} + 17'(b_evt) + 17'(r_evt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt <= '0;
        else     err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomised bench for axi_mem_responder against a burst-level memory model kept in the bench.
// Expected err_cnt_o follows whether AXI_MEM_RESP_ERRCNT_EN is defined for the build.
module tb_axi_mem_responder;
    localparam int          MW   = 256;
    localparam logic [63:0] BASE = 64'h1000;
`ifdef AXI_MEM_RESP_ERRCNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic [15:0] err_cnt;

    axi_mem_responder_if #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(5),
                           .AXI_USER_WIDTH(1)) bus ();

    axi_mem_responder #(
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(5), .AXI_USER_WIDTH(1),
        .MEM_WORDS(MW), .BASE_ADDR(BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .slave     (bus),
        .busy_o    (busy),
        .err_cnt_o (err_cnt)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          exp_err = 0;
    logic [63:0] mdl [MW];
    logic [63:0] wdat [512];
    logic [7:0]  wstb [512];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Response for one beat at byte address a; idx is the model word when OKAY
    function automatic logic [1:0] beat_decode(input logic [63:0] a, input bit bad_burst, output int idx);
        logic [63:0] w;
        idx = 0;
        if (bad_burst) return 2'b10;
        w = (a - BASE) / 8;
        if (w >= 64'(MW)) return 2'b11;
        idx = int'(w);
        return 2'b00;
    endfunction

    function automatic logic [63:0] beat_addr(input logic [63:0] start, input logic [1:0] burst, input int k);
        if (burst == 2'b00) return start;
        return start - (start % 8) + 64'(k) * 8;
    endfunction

    task automatic check_err(input string tag);
        check(tag, err_cnt, ERRCNT_EN ? 16'(exp_err) : 16'd0);
    endtask

    task automatic send_addr(input bit wr, input logic [4:0] id, input logic [63:0] addr,
                             input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size);
        int t = 0;
        @(negedge clk);
        if (wr) begin
            bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
            bus.aw_burst = burst; bus.aw_size = size; bus.aw_valid = 1'b1;
            while (!bus.aw_ready && t < 200) begin @(negedge clk); t++; end
            check("aw_wait", 128'(t >= 200), 128'(0));
        end else begin
            bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
            bus.ar_burst = burst; bus.ar_size = size; bus.ar_valid = 1'b1;
            while (!bus.ar_ready && t < 200) begin @(negedge clk); t++; end
            check("ar_wait", 128'(t >= 200), 128'(0));
        end
        @(posedge clk); #1;
        if (wr) bus.aw_valid = 1'b0;
        else    bus.ar_valid = 1'b0;
        @(negedge clk);
        if (wr) check("w_ready_lat", bus.w_ready, 1);
        else    check("r_valid_lat", bus.r_valid, 1);
        check("busy", busy, 1);
    endtask

    // Sends n W beats from wdat/wstb against an AW of length len+1
    task automatic do_write(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int n);
        logic [1:0] exp_resp = 2'b00;
        logic [1:0] r;
        bit         bb = (burst == 2'b10) || (size != 3'd3);
        bit         tmo = 1'b0;
        int         idx, t;
        for (int k = 0; k < n; k++) begin
            if (k > int'(len)) r = 2'b10;
            else r = beat_decode(beat_addr(addr, burst, k), bb, idx);
            if (r == 2'b00)
                for (int b = 0; b < 8; b++) if (wstb[k][b]) mdl[idx][b*8 +: 8] = wdat[k][b*8 +: 8];
            exp_resp = rmax(exp_resp, r);
        end
        if (n != int'(len) + 1) exp_resp = rmax(exp_resp, 2'b10);

        send_addr(1'b1, id, addr, len, burst, size);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(3) == 0) @(negedge clk);
            bus.w_data = wdat[k]; bus.w_strb = wstb[k]; bus.w_last = (k == n - 1); bus.w_valid = 1'b1;
            t = 0;
            while (!bus.w_ready && t < 200) begin @(negedge clk); t++; end
            if (t >= 200) tmo = 1'b1;
            @(posedge clk); #1;
            bus.w_valid = 1'b0; bus.w_last = 1'b0;
            @(negedge clk);
        end
        check("w_wait", 128'(tmo), 128'(0));
        check("b_valid_lat", bus.b_valid, 1);
        repeat ($urandom_range(2)) @(negedge clk);
        check("b_resp", {bus.b_valid, bus.b_id, bus.b_resp}, {1'b1, id, exp_resp});
        bus.b_ready = 1'b1;
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
        if (exp_resp != 2'b00) exp_err++;
        @(negedge clk);
        check("aw_ready_ret", {bus.aw_ready, bus.b_valid}, 2'b10);
        check_err("w_err_cnt");
    endtask

    task automatic do_read(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input bit rnd);
        bit          bb = (burst == 2'b10) || (size != 3'd3);
        bit          any_err = 1'b0;
        int          beat = 0;
        int          t = 0;
        int          idx;
        logic [1:0]  r;
        logic [63:0] d;
        send_addr(1'b0, id, addr, len, burst, size);
        while (beat <= int'(len) && t < 4000) begin
            bus.r_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            if (bus.r_valid && bus.r_ready) begin
                r = beat_decode(beat_addr(addr, burst, beat), bb, idx);
                d = (r == 2'b00) ? mdl[idx] : 64'd0;
                check("r_beat", {bus.r_id, bus.r_resp, bus.r_last, bus.r_data},
                      {id, r, 1'(beat == int'(len)), d});
                if (r != 2'b00) any_err = 1'b1;
                beat++;
            end
            @(posedge clk); #1;
            bus.r_ready = 1'b0;
            @(negedge clk);
            t++;
        end
        check("r_wait", 128'(t >= 4000), 128'(0));
        check("ar_ready_ret", {bus.ar_ready, bus.r_valid}, 2'b10);
        if (any_err) exp_err++;
        check_err("r_err_cnt");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        int          n;

        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0; bus.aw_valid = 1'b0;
        bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0; bus.b_ready = 1'b0;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_vals", {bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid, bus.r_valid, bus.r_last, busy},
              7'b1100000);
        check("rst_err", err_cnt, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst", {bus.aw_ready, bus.ar_ready, busy}, 3'b110);

        // Fill the whole memory with one 256-beat INCR burst
        for (int k = 0; k < MW; k++) begin wdat[k] = {$urandom, $urandom}; wstb[k] = 8'hFF; end
        do_write(5'h01, BASE, 8'd255, 2'b01, 3'd3, MW);

        for (int k = 0; k < 4; k++) begin wdat[k] = 64'(k + 1); wstb[k] = 8'hFF; end
        do_write(5'h13, BASE + 64'h40, 8'd3, 2'b01, 3'd3, 4);
        do_read(5'h13, BASE + 64'h40, 8'd3, 2'b01, 3'd3, 1'b0);
        do_read(5'h13, BASE + 64'h40, 8'd3, 2'b01, 3'd3, 1'b1);

        wdat[0] = 64'hAAAAAAAAAAAAAAAA; wstb[0] = 8'hFF;
        do_write(5'h02, BASE + 64'h80, 8'd0, 2'b01, 3'd3, 1);
        wdat[0] = 64'h1111111111111111; wstb[0] = 8'h0F;
        do_write(5'h02, BASE + 64'h80, 8'd0, 2'b01, 3'd3, 1);
        do_read(5'h02, BASE + 64'h80, 8'd0, 2'b01, 3'd3, 1'b0);

        do_read(5'h03, BASE + 64'(MW) * 8, 8'd1, 2'b01, 3'd3, 1'b0);
        do_read(5'h04, BASE - 64'd8, 8'd0, 2'b01, 3'd3, 1'b1);
        do_read(5'h05, BASE + 64'(MW - 2) * 8, 8'd3, 2'b01, 3'd3, 1'b0);

        for (int k = 0; k < 4; k++) begin wdat[k] = {$urandom, $urandom}; wstb[k] = 8'hFF; end
        do_write(5'h06, BASE + 64'h40, 8'd3, 2'b10, 3'd3, 4);
        do_read(5'h06, BASE + 64'h40, 8'd3, 2'b01, 3'd3, 1'b0);

        for (int k = 0; k < 4; k++) begin wdat[k] = {$urandom, $urandom}; wstb[k] = 8'hFF; end
        do_write(5'h07, BASE + 64'h100, 8'd3, 2'b01, 3'd3, 2);
        do_read(5'h07, BASE + 64'h100, 8'd3, 2'b01, 3'd3, 1'b0);
        do_write(5'h08, BASE + 64'h200, 8'd1, 2'b01, 3'd3, 4);
        do_read(5'h08, BASE + 64'h200, 8'd3, 2'b01, 3'd3, 1'b0);
        do_write(5'h09, BASE + 64'h300, 8'd2, 2'b00, 3'd3, 3);
        do_read(5'h09, BASE + 64'h300, 8'd2, 2'b00, 3'd3, 1'b1);
        do_read(5'h0A, BASE, 8'd1, 2'b01, 3'd2, 1'b0);

        // Write error (WRAP) and read error (out of range) complete in the same cycle
        @(negedge clk);
        bus.aw_id = 5'h0A; bus.aw_addr = BASE; bus.aw_len = 8'd0; bus.aw_burst = 2'b10; bus.aw_size = 3'd3;
        bus.aw_valid = 1'b1;
        bus.w_data = 64'hDEADBEEF; bus.w_strb = 8'hFF; bus.w_last = 1'b1; bus.w_valid = 1'b1;
        bus.ar_id = 5'h0B; bus.ar_addr = BASE + 64'(MW) * 8; bus.ar_len = 8'd0; bus.ar_burst = 2'b01;
        bus.ar_size = 3'd3; bus.ar_valid = 1'b1;
        @(posedge clk); #1;
        bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
        @(posedge clk); #1;
        bus.w_valid = 1'b0; bus.w_last = 1'b0;
        @(negedge clk);
        check("conc_resp", {bus.b_valid, bus.r_valid, bus.b_resp, bus.b_id, bus.b_user,
                            bus.r_resp, bus.r_id, bus.r_last, bus.r_user, bus.r_data},
              {2'b11, 2'b10, 5'h0A, 1'b0, 2'b11, 5'h0B, 1'b1, 1'b0, 64'd0});
        bus.b_ready = 1'b1; bus.r_ready = 1'b1;
        @(posedge clk); #1;
        bus.b_ready = 1'b0; bus.r_ready = 1'b0;
        exp_err += 2;
        @(negedge clk);
        check_err("conc_err_cnt");
        do_read(5'h0C, BASE, 8'd0, 2'b01, 3'd3, 1'b0);

        for (int op = 0; op < 40; op++) begin
            if ($urandom_range(9) == 0) a = BASE - 64'(8 * (1 + $urandom_range(3)));
            else a = BASE + 64'($urandom_range(MW + 2)) * 8 + 64'($urandom_range(7));
            len   = 8'($urandom_range(7));
            burst = 2'($urandom_range(2));
            size  = ($urandom_range(7) == 0) ? 3'd2 : 3'd3;
            case ($urandom_range(5))
                0:       n = (len == 0) ? 1 : int'(len);
                1:       n = int'(len) + 2;
                default: n = int'(len) + 1;
            endcase
            if ($urandom_range(1) == 0) begin
                for (int k = 0; k < n; k++) begin wdat[k] = {$urandom, $urandom}; wstb[k] = 8'($urandom); end
                do_write(5'($urandom), a, len, burst, size, n);
            end else begin
                do_read(5'($urandom), a, len, burst, size, 1'($urandom_range(1)));
            end
        end

        // Reset during a 4-beat read, after beat 1 has been accepted
        send_addr(1'b0, 5'h0D, BASE + 64'h40, 8'd3, 2'b01, 3'd3);
        bus.r_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.r_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", bus.r_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_abort", {bus.r_valid, bus.r_last, busy}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        exp_err = 0;
        @(negedge clk);
        check("rst_recover", {bus.ar_ready, bus.aw_ready, busy, bus.r_valid, bus.b_valid}, 5'b11000);
        check_err("rst_err_cnt");
        do_read(5'h0E, BASE + 64'h40, 8'd3, 2'b01, 3'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
